// File: rtl/small_lpf_inverse.sv
// ---------------------------------------------------------------------------
// small_lpf_inverse
//   Inverse (pre-emphasis) of the small exponential low-pass filter
//     y[n] = y[n-1] + ((x[n] - y[n-1]) >>> FILT_BITS)
//   reconstructing
//     x[n] = y[n-1] + ((y[n] - y[n-1]) <<< FILT_BITS)
//   with optional saturation. Two register stages, enable-gated sample stream.
//
// Parameters
//   WIDTH      signed sample width (input and output)
//   FILT_BITS  shift of the matching LPF; emphasis gain is 2^FILT_BITS
//   SAT        1 = clamp on overflow, 0 = two's-complement wrap to WIDTH
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   sample strobe; dataIn consumed on a rising edge while high
//   clr       in   synchronous flush: unprime, clear satFlag, drop in-flight data
//   dataIn    in   signed input sample (LPF output)
//   dataOut   out  signed reconstructed sample
//   outValid  out  one-cycle pulse per produced sample
//   satFlag   out  sticky overflow indicator (clip or wrap happened)
// ---------------------------------------------------------------------------
module small_lpf_inverse #(
  parameter int WIDTH     = 8,
  parameter int FILT_BITS = 5,
  parameter int SAT       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             outValid,
  output logic             satFlag
);

  // Sum width: (WIDTH+1)-bit difference shifted by FILT_BITS, plus one carry
  // bit for adding the WIDTH-bit base.
  localparam int SW = WIDTH + FILT_BITS + 2;

  typedef enum logic {UNPRIMED, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   diff;
  logic             v1;

  logic [SW-1:0]      base_ext;
  logic [SW-1:0]      diff_ext;
  logic [SW-1:0]      sum;
  logic [SW-WIDTH:0]  upper;
  logic               ovf;
  logic [WIDTH-1:0]   result;

  // Stage 2 arithmetic. The sum fits in WIDTH bits exactly when every bit
  // from the WIDTH-1 sign position upward is identical.
  always_comb begin
    base_ext = {{(SW-WIDTH){base[WIDTH-1]}}, base};
    diff_ext = {{(SW-WIDTH-1){diff[WIDTH]}}, diff};
    sum      = base_ext + (diff_ext << FILT_BITS);
    upper    = sum[SW-1:WIDTH-1];
    ovf      = !((&upper) || (~|upper));
    result   = sum[WIDTH-1:0];
    if ((SAT != 0) && ovf) begin
      result = sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNPRIMED;
      prev     <= '0;
      base     <= '0;
      diff     <= '0;
      v1       <= 1'b0;
      dataOut  <= '0;
      outValid <= 1'b0;
      satFlag  <= 1'b0;
    end else if (clr) begin
      // Flush: the sample presented with clr and anything in flight is lost.
      state    <= UNPRIMED;
      prev     <= '0;
      v1       <= 1'b0;
      outValid <= 1'b0;
      satFlag  <= 1'b0;
    end else begin
      // Stage 2
      outValid <= v1;
      if (v1) begin
        dataOut <= result;
        if (ovf) begin
          satFlag <= 1'b1;
        end
      end

      // Stage 1
      v1 <= en;
      if (en) begin
        case (state)
          UNPRIMED: begin
            // No history yet: zero difference passes the sample through.
            base  <= dataIn;
            diff  <= '0;
            state <= RUN;
          end
          default: begin
            base <= prev;
            diff <= {dataIn[WIDTH-1], dataIn} - {prev[WIDTH-1], prev};
          end
        endcase
        prev <= dataIn;
      end
    end
  end

endmodule

// File: tb/tb_small_lpf_inverse.sv
module tb_small_lpf_inverse;

  localparam int W  = 8;
  localparam int FB = 5;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] din   = '0;

  logic [W-1:0] out_s, out_w;
  logic         val_s, val_w, sat_s, sat_w;

  always #5 clk = ~clk;

  small_lpf_inverse #(.WIDTH(W), .FILT_BITS(FB), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dataIn(din),
    .dataOut(out_s), .outValid(val_s), .satFlag(sat_s)
  );

  small_lpf_inverse #(.WIDTH(W), .FILT_BITS(FB), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dataIn(din),
    .dataOut(out_w), .outValid(val_w), .satFlag(sat_w)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: integer arithmetic on whole samples plus a one-deep
  // "pending result" slot standing in for the two-cycle latency.
  bit         m_primed;
  int         m_prev;
  bit         m_pv;
  bit         m_povf;
  logic [7:0] m_ps, m_pw;
  logic [7:0] e_out_s, e_out_w;
  bit         e_val, e_sat;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(string tag, logic obs, logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed = 0; m_prev = 0; m_pv = 0; m_povf = 0;
    m_ps = '0; m_pw = '0;
    e_out_s = '0; e_out_w = '0; e_val = 0; e_sat = 0;
  endtask

  task automatic model_edge(bit e, bit c, logic [7:0] d);
    int x;
    int di;
    if (c) begin
      m_primed = 0; m_prev = 0; m_pv = 0; e_val = 0; e_sat = 0;
    end else begin
      e_val = m_pv;
      if (m_pv) begin
        e_out_s = m_ps;
        e_out_w = m_pw;
        if (m_povf) e_sat = 1;
      end
      m_pv = e;
      if (e) begin
        di = int'($signed(d));
        x  = m_primed ? m_prev + (di - m_prev) * (1 << FB) : di;
        m_povf = (x > 127) || (x < -128);
        m_ps = (x > 127) ? 8'd127 : ((x < -128) ? 8'h80 : x[7:0]);
        m_pw = x[7:0];
        m_prev   = di;
        m_primed = 1;
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "/out_sat"},  out_s, e_out_s);
    check({tag, "/out_wrap"}, out_w, e_out_w);
    check_bit({tag, "/valid_sat"},  val_s, e_val);
    check_bit({tag, "/valid_wrap"}, val_w, e_val);
    check_bit({tag, "/flag_sat"},   sat_s, e_sat);
    check_bit({tag, "/flag_wrap"},  sat_w, e_sat);
  endtask

  task automatic step(bit e, bit c, logic [7:0] d, string tag);
    en = e; clr = c; din = d;
    @(posedge clk);
    model_edge(e, c, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int   x, x_prev, lpf_y, settle, err;
    logic [7:0] y8;

    // Reset state
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // 1: first sample passes through
    step(1, 0, 8'd10, "t1_in");
    step(0, 0, 8'd0,  "t1_out");
    check("t1_const", out_s, 8'd10);

    // 2: constant input reproduces itself, valid held high
    step(1, 1, 8'd0, "t2_clr");
    step(1, 0, 8'd50, "t2_prime");
    for (int i = 0; i < 20; i++) step(1, 0, 8'd50, "t2_hold");
    check("t2_const", out_s, 8'd50);

    // 3: gain of 32 on the difference
    step(1, 1, 8'd0, "t3_clr");
    step(1, 0, 8'd0, "t3_prime");
    step(1, 0, 8'd3, "t3_a");
    step(1, 0, 8'd2, "t3_b");
    check("t3_96", out_s, 8'd96);
    step(0, 0, 8'd0, "t3_c");
    check("t3_m29", out_s, 8'hE3);

    // 4: overflow -> clip / wrap, sticky flag, cleared by clr
    step(1, 1, 8'd0, "t4_clr");
    step(1, 0, 8'd0, "t4_prime");
    step(1, 0, 8'd4, "t4_big");
    step(0, 0, 8'd0, "t4_out");
    check("t4_clip", out_s, 8'd127);
    check("t4_wrap", out_w, 8'h80);
    check_bit("t4_flag", sat_s, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 0, 8'd4, "t4_sticky");
    step(0, 1, 8'd0, "t4_clr2");
    check_bit("t4_flag_clr", sat_s, 1'b0);
    step(1, 0, 8'd77, "t4_unprimed");
    step(0, 0, 8'd0, "t4_pass");
    check("t4_pass_const", out_s, 8'd77);

    // 5: enable gap does not disturb history
    step(1, 1, 8'd0, "t5_clr");
    step(1, 0, 8'd20, "t5_prime");
    for (int i = 0; i < 3; i++) step(0, 0, 8'd99, "t5_gap");
    check_bit("t5_gap_valid", val_s, 1'b0);
    step(1, 0, 8'd21, "t5_in");
    step(0, 0, 8'd0, "t5_out");
    check("t5_52", out_s, 8'd52);

    // Randomized stream with gaps and occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
           8'($urandom), "rand");
    end

    // 6: sine through the LPF, then this block; async reset mid-stream
    step(1, 1, 8'd0, "t6_clr");
    lpf_y  = 0;
    x_prev = 0;
    settle = 0;
    for (int n = 0; n < 300; n++) begin
      x     = int'(127.0 * $sin(2.0 * 3.14159265358979 * n / 50.0));
      lpf_y = lpf_y + ((x - lpf_y) >>> FB);
      y8    = lpf_y[7:0];
      step(1, 0, y8, "t6_sine");
      if (val_s) begin
        settle++;
        if (settle >= 2) begin
          err = int'($signed(out_s)) - x_prev;
          check_bit("t6_tol", (err <= 32) && (err >= -32), 1'b1);
        end
      end
      x_prev = x;
      if (n == 150) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_async_rst");
        #1 rst_n = 1'b1;
        settle = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
